// File: rtl/sort3_pkg.sv
// Shared types and encodings for the streaming three-value sorter.
package sort3_pkg;

  localparam int SORT3_WIDTH = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    EMIT    = 2'd2
  } sort3_state_t;

  // Slot order of collected words
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;

  // Emit position within a sorted triple
  localparam logic [1:0] IDX_FIRST  = 2'd0;
  localparam logic [1:0] IDX_SECOND = 2'd1;
  localparam logic [1:0] IDX_LAST   = 2'd2;

endpackage

// File: rtl/sort3_stream_if.sv
// Valid/ready input and output streams of sort3_stream; slave is the sorter side.
interface sort3_stream_if
  import sort3_pkg::*;
#(
  parameter int WIDTH = SORT3_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sort3_core.sv
// Combinational three-input sorting network: three strict unsigned compares, then max/mid/min select.
module sort3_core
  import sort3_pkg::*;
#(
  parameter int WIDTH = SORT3_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] mid_o,
  output logic [WIDTH-1:0] min_o
);

  logic a_gt_b;
  logic a_gt_c;
  logic b_gt_c;

  assign a_gt_b = (a_i > b_i);
  assign a_gt_c = (a_i > c_i);
  assign b_gt_c = (b_i > c_i);

  // Each branch picks three distinct inputs, so ties still preserve the multiset
  assign max_o = a_gt_b ? (a_gt_c ? a_i : c_i) : (b_gt_c ? b_i : c_i);
  assign min_o = a_gt_b ? (b_gt_c ? c_i : b_i) : (a_gt_c ? c_i : a_i);
  assign mid_o = a_gt_b ? (b_gt_c ? b_i : (a_gt_c ? c_i : a_i))
                        : (a_gt_c ? a_i : (b_gt_c ? c_i : b_i));

endmodule

// File: rtl/sort3_stream.sv
// Streaming sorter: collects three words, sorts them in one cycle, emits largest first.
// Define SORT3_STREAM_ASCEND_EN to emit smallest first instead.
module sort3_stream
  import sort3_pkg::*;
#(
  parameter int WIDTH = SORT3_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  sort3_stream_if.slave bus
);

  sort3_state_t     state_q;
  logic [1:0]       cnt_q;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [WIDTH-1:0] slot_q   [3];
  logic [WIDTH-1:0] sorted_q [3];
  logic [WIDTH-1:0] ord_d    [3];
  logic [WIDTH-1:0] max_w;
  logic [WIDTH-1:0] mid_w;
  logic [WIDTH-1:0] min_w;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;

  sort3_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (slot_q[SLOT_A]),
    .b_i   (slot_q[SLOT_B]),
    .c_i   (slot_q[SLOT_C]),
    .max_o (max_w),
    .mid_o (mid_w),
    .min_o (min_w)
  );

`ifdef SORT3_STREAM_ASCEND_EN
  assign ord_d[IDX_FIRST]  = min_w;
  assign ord_d[IDX_SECOND] = mid_w;
  assign ord_d[IDX_LAST]   = max_w;
`else
  assign ord_d[IDX_FIRST]  = max_w;
  assign ord_d[IDX_SECOND] = mid_w;
  assign ord_d[IDX_LAST]   = min_w;
`endif

  assign idx_d = idx_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= SLOT_A;
      idx_q       <= IDX_FIRST;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        slot_q[i]   <= '0;
        sorted_q[i] <= '0;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.in_valid && in_ready_q) begin
            slot_q[cnt_q] <= bus.in_data;
            if (cnt_q == SLOT_C) begin
              cnt_q      <= SLOT_A;
              in_ready_q <= 1'b0;
              state_q    <= SORT;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        SORT: begin
          // First output word comes straight from the network so EMIT starts presenting it at once
          for (int i = 0; i < 3; i++) sorted_q[i] <= ord_d[i];
          out_data_q  <= ord_d[IDX_FIRST];
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
          idx_q       <= IDX_FIRST;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (idx_q == IDX_LAST) begin
              idx_q       <= IDX_FIRST;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= COLLECT;
            end else begin
              idx_q      <= idx_d;
              out_data_q <= sorted_q[idx_d];
              out_last_q <= (idx_d == IDX_LAST);
            end
          end
        end
        default: begin
          state_q     <= COLLECT;
          cnt_q       <= SLOT_A;
          idx_q       <= IDX_FIRST;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule
